// File: rtl/axi_pkg.sv
// Shared definitions for the AXI write-burst packer: default widths and FSM state type.
package axi_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int BURST_LEN_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head and occupancy count.
// Storage is not reset; only pointers and count are cleared by rstn.
module sync_fifo
  import axi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // full only looks at the registered count, so a same-cycle pop never opens a full FIFO
  assign full    = (count == DEPTH_C);
  assign push_ok = push && !full;
  assign pop_ok  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Data storage: written on accepted push, never reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_wburst_packer.sv
// Buffers a valid/ready sample stream and emits fixed-length AXI W-channel bursts.
// A flush request drains whatever is buffered as one short burst.
module axi_wburst_packer
  import axi_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] M_WDATA,
  output logic              M_WVALID,
  output logic              M_WLAST,
  input  logic              S_WREADY,
  output logic [CNT_W-1:0]  level,
  output logic              burst_done
);

  localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] beats;
  logic [CNT_W-1:0] beats_nxt;
  logic [CNT_W-1:0] beat_idx;
  logic [CNT_W-1:0] beat_idx_nxt;
  logic             done_nxt;
  logic             flush_pend;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             pop;

  assign pop      = M_WVALID && S_WREADY;
  assign in_ready = !full;
  assign level    = count;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (pop),
    .head  (M_WDATA),
    .count (count),
    .full  (full)
  );

  // State, beat bookkeeping and the one-cycle completion pulse
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      beats      <= '0;
      beat_idx   <= '0;
      burst_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      beats      <= beats_nxt;
      beat_idx   <= beat_idx_nxt;
      burst_done <= done_nxt;
    end
  end

  // Flush request is remembered until the FSM is idle with an empty FIFO
  always_ff @(posedge clk) begin
    if (!rstn) begin
      flush_pend <= 1'b0;
    end else if (flush) begin
      flush_pend <= 1'b1;
    end else if (state == IDLE && count == '0) begin
      flush_pend <= 1'b0;
    end
  end

  // Burst sequencing; outputs depend only on registered state, never on S_WREADY
  always_comb begin
    state_nxt    = state;
    beats_nxt    = beats;
    beat_idx_nxt = beat_idx;
    done_nxt     = 1'b0;
    M_WVALID     = 1'b0;
    M_WLAST      = 1'b0;
    case (state)
      IDLE: begin
        if (count >= BURST_LEN_C) begin
          beats_nxt    = BURST_LEN_C;
          beat_idx_nxt = '0;
          state_nxt    = BURST;
        end else if (flush_pend && count != '0) begin
          beats_nxt    = count;
          beat_idx_nxt = '0;
          state_nxt    = BURST;
        end
      end
      BURST: begin
        M_WVALID = 1'b1;
        M_WLAST  = (beat_idx == beats - 1'b1);
        if (S_WREADY) begin
          if (M_WLAST) begin
            state_nxt    = IDLE;
            beat_idx_nxt = '0;
            done_nxt     = 1'b1;
          end else begin
            beat_idx_nxt = beat_idx + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_wburst_packer.sv
// Directed bench for axi_wburst_packer: reset, full bursts, back-pressure,
// flush, full FIFO with wrap, streaming push+pop, reset mid-burst.
module tb_axi_wburst_packer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] M_WDATA;
  logic        M_WVALID;
  logic        M_WLAST;
  logic        S_WREADY;
  logic [4:0]  level;
  logic        burst_done;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic [31:0] obs_data[$];
  logic        obs_last[$];

  always #5 clk = ~clk;

  axi_wburst_packer #(
    .DATA_W    (32),
    .BURST_LEN (4),
    .DEPTH     (16),
    .CNT_W     (5)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .M_WDATA    (M_WDATA),
    .M_WVALID   (M_WVALID),
    .M_WLAST    (M_WLAST),
    .S_WREADY   (S_WREADY),
    .level      (level),
    .burst_done (burst_done)
  );

  // Record every W handshake and every completion pulse
  always @(posedge clk) begin
    if (rstn && M_WVALID && S_WREADY) begin
      obs_data.push_back(M_WDATA);
      obs_last.push_back(M_WLAST);
    end
    if (rstn && burst_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push four consecutive values with the slave always ready and check every beat
  task automatic full_burst(input logic [31:0] base);
    S_WREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data  = base + 32'(i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("fb_level4", level, 4);
    check("fb_idle_gap", M_WVALID, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      check("fb_wvalid", M_WVALID, 1);
      check("fb_wdata", M_WDATA, base + 32'(k));
      check("fb_wlast", M_WLAST, (k == 3) ? 1 : 0);
      tick();
    end
    check("fb_done", burst_done, 1);
    check("fb_wvalid_off", M_WVALID, 0);
    check("fb_level0", level, 0);
    tick();
    check("fb_done_pulse", burst_done, 0);
  endtask

  initial begin
    logic        rdy_seq [7];
    int          b;
    logic [4:0]  lv;
    logic        p;
    logic        q;
    int          idx;
    int          cyc;

    rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset held for two edges while traffic is offered
    rstn = 1'b0; in_valid = 1'b1; in_data = 32'hdead; flush = 1'b0; S_WREADY = 1'b1;
    tick();
    tick();
    check("rst_wvalid", M_WVALID, 0);
    check("rst_wlast", M_WLAST, 0);
    check("rst_level", level, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_done", burst_done, 0);
    rstn = 1'b1; in_valid = 1'b0;
    tick();
    check("post_rst_level", level, 0);

    // Full burst with continuous ready
    full_burst(32'd1);

    // Back-pressure pattern during a burst
    S_WREADY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'd10 + 32'(i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    b = 0;
    for (int i = 0; i < 7; i++) begin
      S_WREADY = rdy_seq[i];
      check("bp_wvalid", M_WVALID, 1);
      check("bp_wdata", M_WDATA, 32'd10 + 32'(b));
      check("bp_wlast", M_WLAST, (b == 3) ? 1 : 0);
      tick();
      if (rdy_seq[i]) b++;
    end
    S_WREADY = 1'b1;
    check("bp_done", burst_done, 1);
    check("bp_wvalid_off", M_WVALID, 0);
    check("bp_level", level, 0);

    // Flush of a two-sample partial burst
    in_data = 32'd7; in_valid = 1'b1; tick();
    in_data = 32'd8; tick();
    in_valid = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    check("fl_wait", M_WVALID, 0);
    check("fl_level", level, 2);
    tick();
    check("fl_b0_valid", M_WVALID, 1);
    check("fl_b0_data", M_WDATA, 7);
    check("fl_b0_last", M_WLAST, 0);
    tick();
    check("fl_b1_data", M_WDATA, 8);
    check("fl_b1_last", M_WLAST, 1);
    tick();
    check("fl_done", burst_done, 1);
    check("fl_level0", level, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fl_quiet", M_WVALID, 0);
    end

    // Fill the FIFO completely while the slave stalls
    S_WREADY = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_data = 32'(i); in_valid = 1'b1;
      tick();
    end
    in_data = 32'd99;
    check("full_in_ready", in_ready, 0);
    check("full_level", level, 16);
    tick();
    check("full_reject", level, 16);
    in_valid = 1'b0;
    obs_data.delete(); obs_last.delete(); done_cnt = 0;
    S_WREADY = 1'b1;
    for (int t = 0; t < 200 && obs_data.size() < 16; t++) tick();
    tick(); tick();
    check("full_drain_cnt", obs_data.size(), 16);
    for (int i = 0; i < 16 && i < obs_data.size(); i++) begin
      check("full_data", obs_data[i], 32'(i));
      check("full_last", obs_last[i], (i % 4 == 3) ? 1 : 0);
    end
    check("full_bursts", done_cnt, 4);
    check("full_level0", level, 0);

    // Streaming pushes overlapping bursts: level holds on push+pop cycles
    obs_data.delete(); obs_last.delete();
    S_WREADY = 1'b1;
    idx = 0; cyc = 0;
    while (idx < 64 && cyc < 500) begin
      in_data = 32'h100 + 32'(idx); in_valid = 1'b1;
      lv = level;
      p = in_ready;
      q = M_WVALID;
      tick();
      cyc++;
      if (p && q) check("simul_level", level, lv);
      if (p) idx++;
    end
    in_valid = 1'b0;
    check("stream_pushed", idx, 64);
    for (int t = 0; t < 200 && obs_data.size() < 64; t++) tick();
    tick(); tick();
    check("stream_cnt", obs_data.size(), 64);
    for (int i = 0; i < 64 && i < obs_data.size(); i++) begin
      check("stream_data", obs_data[i], 32'h100 + 32'(i));
    end
    check("stream_level0", level, 0);

    // Reset while a burst is stalled mid-flight
    S_WREADY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'd31 + 32'(i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    check("mid_pre_valid", M_WVALID, 1);
    rstn = 1'b0; in_valid = 1'b1; in_data = 32'd55;
    tick(); tick();
    check("mid_rst_wvalid", M_WVALID, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_done", burst_done, 0);
    rstn = 1'b1; in_valid = 1'b0; S_WREADY = 1'b1;
    tick();
    full_burst(32'd21);
    for (int i = 0; i < 3; i++) tick();
    check("end_quiet", M_WVALID, 0);
    check("end_level", level, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
